// File: rtl/cattrap_pkg.sv
// Shared types for the cat-trap board: grid geometry and
// the move_capture state encoding.
package cattrap_pkg;

  localparam int GRID_N = 8;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    OFFER    = 2'd2,
    REL_DB   = 2'd3
  } mc_state_t;

endpackage

// File: rtl/onehot_to_index.sv
// One-hot bank to binary index, with a flag that is set only
// when exactly one bit of the bank is high.
module onehot_to_index
  import cattrap_pkg::*;
(
  input  logic [GRID_N-1:0] in,
  output logic [IDX_W-1:0]  idx,
  output logic              onehot_ok
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < GRID_N; i++) begin
      if (in[i]) idx = idx | IDX_W'(i);
    end
  end

  // Non-zero with no second bit: clearing the lowest set bit leaves zero
  assign onehot_ok = (in != '0) &&
                     ((in & (in - GRID_N'(1))) == '0);

endmodule

// File: rtl/move_capture.sv
// Debounced commit button plus one-hot Row/Col capture, offered as a move
// on valid/ready. Define MOVE_CAPTURE_ERR_COUNT_EN to add err_count.
module move_capture
  import cattrap_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              BtnU,
  input  logic [GRID_N-1:0] Row,
  input  logic [GRID_N-1:0] Col,
  output logic              move_valid,
  input  logic              move_ready,
  output logic [IDX_W-1:0]  move_row,
  output logic [IDX_W-1:0]  move_col,
  output logic              invalid_pulse,
`ifdef MOVE_CAPTURE_ERR_COUNT_EN
  output logic [7:0]        err_count,
`endif
  output logic              busy
);

  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic              btn_m, btn_s;
  logic [GRID_N-1:0] row_m, row_s, col_m, col_s;
  logic [IDX_W-1:0]  row_idx, col_idx;
  logic              row_ok, col_ok;

  mc_state_t         state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [IDX_W-1:0]  row_q, row_n, col_q, col_n;
  logic              inv_q, inv_n;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      row_m <= '0;
      row_s <= '0;
      col_m <= '0;
      col_s <= '0;
    end else begin
      btn_m <= BtnU;
      btn_s <= btn_m;
      row_m <= Row;
      row_s <= row_m;
      col_m <= Col;
      col_s <= col_m;
    end
  end

  onehot_to_index u_row (
    .in        (row_s),
    .idx       (row_idx),
    .onehot_ok (row_ok)
  );

  onehot_to_index u_col (
    .in        (col_s),
    .idx       (col_idx),
    .onehot_ok (col_ok)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    row_n   = row_q;
    col_n   = col_q;
    inv_n   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (btn_s) begin
          state_n = PRESS_DB;
          cnt_n   = CNT_W'(1);
        end
      end
      PRESS_DB: begin
        if (!btn_s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == DB_MAX) begin
          cnt_n = '0;
          if (row_ok && col_ok) begin
            state_n = OFFER;
            row_n   = row_idx;
            col_n   = col_idx;
          end else begin
            state_n = REL_DB;
            inv_n   = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      OFFER: begin
        if (move_ready) begin
          state_n = REL_DB;
          cnt_n   = '0;
        end
      end
      REL_DB: begin
        if (btn_s) begin
          cnt_n = '0;
        end else if (cnt == DB_MAX) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      row_q <= '0;
      col_q <= '0;
      inv_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      row_q <= row_n;
      col_q <= col_n;
      inv_q <= inv_n;
    end
  end

`ifdef MOVE_CAPTURE_ERR_COUNT_EN
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      err_count <= '0;
    end else if (inv_q && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

  // Decoded from the state register so reset clears them at once
  assign move_valid    = (state == OFFER);
  assign busy          = (state != IDLE);
  assign move_row      = row_q;
  assign move_col      = col_q;
  assign invalid_pulse = inv_q;

endmodule

// File: tb/tb_move_capture.sv
// Directed and randomized checks of move_capture against a
// run-length reference model of the debounce and capture rules.
module tb_move_capture;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       BtnU = 1'b0;
  logic       move_ready = 1'b0;
  logic [7:0] Row = 8'h00;
  logic [7:0] Col = 8'h00;
  logic       move_valid;
  logic [2:0] move_row;
  logic [2:0] move_col;
  logic       invalid_pulse;
  logic       busy;
`ifdef MOVE_CAPTURE_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: two-deep input delay, run lengths
  bit [16:0] d1, d2;
  bit        m_offer, m_rel, m_pulse;
  int        m_hi, m_lo, m_row, m_col, m_err;

  always #5 clk = ~clk;

  move_capture #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (3)
  ) dut (
    .clk           (clk),
    .Reset         (Reset),
    .BtnU          (BtnU),
    .Row           (Row),
    .Col           (Col),
    .move_valid    (move_valid),
    .move_ready    (move_ready),
    .move_row      (move_row),
    .move_col      (move_col),
    .invalid_pulse (invalid_pulse),
`ifdef MOVE_CAPTURE_ERR_COUNT_EN
    .err_count     (err_count),
`endif
    .busy          (busy)
  );

  function automatic int idx_of(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    d1 = '0; d2 = '0;
    m_offer = 0; m_rel = 0; m_pulse = 0;
    m_hi = 0; m_lo = 0; m_err = 0;
  endtask

  task automatic model_edge();
    bit [16:0]  cur;
    bit         s;
    logic [7:0] rs, cs;
    if (Reset) begin
      model_reset();
      return;
    end
    cur = d2;
    d2  = d1;
    d1  = {BtnU, Row, Col};
    if (m_pulse && m_err < 255) m_err++;
    m_pulse = 0;
    s  = cur[16];
    rs = cur[15:8];
    cs = cur[7:0];
    if (m_offer) begin
      if (move_ready) begin
        m_offer = 0; m_rel = 1; m_lo = 0;
      end
    end else if (m_rel) begin
      if (s) m_lo = 0;
      else begin
        m_lo++;
        if (m_lo == D + 1) begin m_rel = 0; m_lo = 0; end
      end
    end else if (s) begin
      m_hi++;
      if (m_hi == D + 1) begin
        m_hi = 0;
        if ($countones(rs) == 1 && $countones(cs) == 1) begin
          m_offer = 1;
          m_row = idx_of(rs);
          m_col = idx_of(cs);
        end else begin
          m_pulse = 1; m_rel = 1; m_lo = 0;
        end
      end
    end else begin
      m_hi = 0;
    end
  endtask

  task automatic check_all();
    chk("valid", move_valid, m_offer);
    chk("busy", busy, m_offer | m_rel | (m_hi > 0));
    chk("invalid", invalid_pulse, m_pulse);
    if (m_offer) begin
      chk("row", move_row, m_row);
      chk("col", move_col, m_col);
    end
`ifdef MOVE_CAPTURE_ERR_COUNT_EN
    chk("err_count", err_count, m_err);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  int first, vcnt, pcnt, hold;

  initial begin
    model_reset();
    step();
    step();
    chk("rst_row", move_row, 0);
    chk("rst_col", move_col, 0);
    Reset = 1'b0;

    // Clean move with the button held throughout
    Row = 8'h04; Col = 8'h20; move_ready = 1'b1; BtnU = 1'b1;
    first = 0; vcnt = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (move_valid) begin
        vcnt++;
        if (first == 0) first = i;
      end
    end
    chk("clean_latency", first, 7);
    chk("clean_one_move", vcnt, 1);
    BtnU = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // Bounce rejection
    vcnt = 0; pcnt = 0;
    for (int r = 0; r < 3; r++) begin
      BtnU = 1'b1;
      for (int i = 0; i < 3; i++) begin
        step(); vcnt += move_valid; pcnt += invalid_pulse;
      end
      BtnU = 1'b0;
      for (int i = 0; i < 2; i++) begin
        step(); vcnt += move_valid; pcnt += invalid_pulse;
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(); vcnt += move_valid; pcnt += invalid_pulse;
    end
    chk("bounce_valid", vcnt, 0);
    chk("bounce_invalid", pcnt, 0);
    chk("bounce_busy", busy, 0);

    // Invalid selections: empty row, then two rows set
    for (int k = 0; k < 2; k++) begin
      Row = (k == 0) ? 8'h00 : 8'h03; Col = 8'h01; BtnU = 1'b1;
      first = 0; vcnt = 0; pcnt = 0;
      for (int i = 1; i <= 12; i++) begin
        step();
        vcnt += move_valid;
        if (invalid_pulse) begin
          pcnt++;
          if (first == 0) first = i;
        end
      end
      chk("inv_at", first, 7);
      chk("inv_width", pcnt, 1);
      chk("inv_valid", vcnt, 0);
`ifdef MOVE_CAPTURE_ERR_COUNT_EN
      chk("inv_errcnt", err_count, k + 1);
`endif
      BtnU = 1'b0;
      for (int i = 0; i < 8; i++) step();
    end

    // Backpressure with switches moving during the offer
    move_ready = 1'b0; Row = 8'h02; Col = 8'h80; BtnU = 1'b1;
    for (int i = 0; i < 7; i++) step();
    chk("bp_valid", move_valid, 1);
    for (int i = 0; i < 10; i++) begin
      Row = 8'($urandom); Col = 8'($urandom);
      step();
    end
    chk("bp_row", move_row, 1);
    chk("bp_col", move_col, 7);
    move_ready = 1'b1;
    step();
    chk("bp_drop", move_valid, 0);

    // Re-arm: short release ignored, long release accepted
    Row = 8'h80; Col = 8'h08;
    BtnU = 1'b0;
    for (int i = 0; i < 3; i++) step();
    BtnU = 1'b1; vcnt = 0;
    for (int i = 0; i < 12; i++) begin step(); vcnt += move_valid; end
    chk("rearm_short", vcnt, 0);
    BtnU = 1'b0;
    for (int i = 0; i < 6; i++) step();
    BtnU = 1'b1; vcnt = 0;
    for (int i = 0; i < 12; i++) begin step(); vcnt += move_valid; end
    chk("rearm_long", vcnt, 1);
    BtnU = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // Randomized button runs, switch patterns and ready
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        BtnU = ~BtnU;
        hold = $urandom_range(1, 9);
      end
      hold--;
      if ($urandom_range(0, 9) < 7) begin
        Row = 8'h01 << $urandom_range(0, 7);
        Col = 8'h01 << $urandom_range(0, 7);
      end else begin
        Row = 8'($urandom); Col = 8'($urandom);
      end
      move_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Reset during an offer
    BtnU = 1'b0; move_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    move_ready = 1'b0; Row = 8'h10; Col = 8'h02; BtnU = 1'b1;
    for (int i = 0; i < 7; i++) step();
    chk("pre_rst_valid", move_valid, 1);
    @(posedge clk);
    model_edge();
    #2;
    Reset = 1'b1; BtnU = 1'b0;
    #1;
    model_reset();
    chk("async_valid", move_valid, 0);
    chk("async_busy", busy, 0);
    step();
    Reset = 1'b0; move_ready = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 15; i++) begin step(); vcnt += move_valid; end
    chk("no_reoffer", vcnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/move_capture.md
Name: move_capture

Overview:
- Input-side counterpart of the top-level one-hot Row/Col → seven-segment display path.
- Turns raw board controls into player moves for the game logic. BtnU is the "commit move" button; Row and Col are the slide-switch banks Sw15..Sw8 and Sw7..Sw0.
- The block synchronises and debounces the button, then samples both switch banks. It checks that each bank is exactly one-hot and encodes each to a 3-bit index.
- Each valid move is offered once to the game FSM on a valid/ready handshake.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive synchronised-stable cycles needed to accept a press or a release (10 ms at 100 MHz). Legal range is 2 or more.
- CNT_W, 20: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk, input, 1: system clock, 100 MHz.
- Reset, input, 1: asynchronous, active-high.
- BtnU, input, 1: raw commit button, asynchronous to clk.
- Row, input, 8: raw row switches {Sw15..Sw8}; bit k selects row k.
- Col, input, 8: raw column switches {Sw7..Sw0}; bit k selects column k.
- move_valid, output, 1: a move is being offered.
- move_ready, input, 1: the consumer accepts the move this cycle.
- move_row, output, 3: row index, stable while move_valid=1.
- move_col, output, 3: column index, stable while move_valid=1.
- invalid_pulse, output, 1: one-cycle pulse when a debounced press has a non-one-hot Row or Col.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Reset, clk: reset is Reset, asynchronous, active-high; clock is clk. Every flop uses posedge clk / posedge Reset.
- Reset values:
  - move_valid=0, move_row=0, move_col=0, invalid_pulse=0, busy=0.
  - FSM=IDLE, counter=0, synchroniser flops=0.
- Synchronisation: BtnU, Row and Col each pass through two flops before any use. All timing below is measured at the synchroniser output btn_s.
- IDLE:
  - Counter held at 0.
  - btn_s=1 → PRESS_DB with counter=1.
- PRESS_DB:
  - btn_s=1 and counter<DEBOUNCE_CYCLES → counter+1.
  - btn_s=0 at any point → IDLE, counter=0 (glitch rejected, no output).
  - btn_s=1 and counter==DEBOUNCE_CYCLES → sample the synchronised Row/Col that cycle.
    - Both one-hot: register the indices, assert move_valid next cycle → OFFER.
    - Otherwise: assert invalid_pulse for exactly one cycle next cycle → REL_DB with counter=0.
- OFFER:
  - move_valid=1; move_row/move_col frozen. Later switch changes do not affect them.
  - Handshake completes when move_valid & move_ready are high on a rising edge. move_valid drops the following cycle → REL_DB with counter=0.
  - The offer is held indefinitely with no timeout. Button activity during OFFER is ignored.
- REL_DB:
  - btn_s=0 → counter+1; btn_s=1 → counter=0.
  - counter==DEBOUNCE_CYCLES with btn_s=0 → IDLE.
  - A single held press therefore produces at most one move.
- Latency: a clean BtnU rise at input cycle 0 gives btn_s=1 at cycle 2, and move_valid (or invalid_pulse) rises at cycle DEBOUNCE_CYCLES+3.
- Encoding: index = position of the single set bit, so Row=8'b0000_0001 → 0 and 8'b1000_0000 → 7.
  - Zero bits set is invalid. Two or more bits set is invalid.
- Counter: saturates and never wraps. It is compared against DEBOUNCE_CYCLES at CNT_W width.
- move_ready while move_valid=0 is ignored.
- Reset mid-operation (including during OFFER) discards the pending move immediately, with no handshake.

Optional Feature:
- Macro MOVE_CAPTURE_ERR_COUNT_EN.
- When defined:
  - Adds output err_count[7:0], reset 0.
  - Increments by 1 on each invalid_pulse and saturates at 8'hFF.
  - Intended for display on the SSD scanner's spare digit.
- When not defined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package cattrap_pkg holds:
  - GRID_N=8 and IDX_W=3.
  - The move_capture state enum {IDLE, PRESS_DB, OFFER, REL_DB}, 2-bit encoding.
- Sub-module onehot_to_index is combinational: in [GRID_N-1:0] → idx [IDX_W-1:0] plus onehot_ok. It is instantiated twice, once for Row and once for Col, and is reusable by the SSD path.

Test Plan (DEBOUNCE_CYCLES=4):
- Clean move: Row=8'h04, Col=8'h20, BtnU held high, move_ready=1 → move_valid rises exactly 7 cycles after BtnU with move_row=2, move_col=5, and is high for 1 cycle. Holding BtnU high produces no second move.
- Bounce rejection: BtnU pulses high for 3 cycles, low for 2, repeated 3 times, then low → no move_valid, no invalid_pulse, busy returns to 0.
- Invalid selection: Row=8'h00 (or 8'h03), Col=8'h01, press → invalid_pulse high for exactly 1 cycle at cycle 7, move_valid stays 0. With MOVE_CAPTURE_ERR_COUNT_EN, err_count goes 0→1.
- Backpressure: move_ready=0 for 10 cycles and switches change during the offer → move_valid held with the indices frozen at their sampled values. move_ready=1 → move_valid drops the next cycle.
- Re-arm: after the handshake, BtnU is released for 3 cycles then pressed again → ignored (still in REL_DB). Released for 5 or more cycles then pressed → a second move is offered.
- Reset mid-OFFER: Reset asserted asynchronously mid-cycle → move_valid=0 and busy=0 immediately, without waiting for a clock edge. After reset, the pending move is never re-offered.
